vga_char_scan: RTL and testbench

VGA_CHAR_SCAN -- requirements
Module: vga_char_scan

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_timing.sv | 42 ++++
 rtl/vga_char_scan.sv | 58 +++++
 tb/tb_vga_char_scan.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster timing constants and the 12-bit colour type.
package vga_pkg;
  localparam int h_visible = 640;
  localparam int h_front = 16;
  localparam int h_sync = 96;
  localparam int h_back = 48;
  localparam int h_total = h_visible + h_front + h_sync + h_back;
  localparam int h_sync_start = h_visible + h_front;
  localparam int h_sync_end = h_sync_start + h_sync;
  localparam int v_visible = 480;
  localparam int v_front = 10;
  localparam int v_sync = 2;
  localparam int v_back = 33;
  localparam int v_total = v_visible + v_front + v_sync + v_back;
  localparam int v_sync_start = v_visible + v_front;
  localparam int v_sync_end = v_sync_start + v_sync;
  localparam int cnt_w = 10;
  typedef logic [cnt_w-1:0] cnt_t;
  typedef logic [11:0] rgb_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters and stage-0 decode, including the character-buffer request.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       first,
  output logic [6:0] hchar,
  output logic [4:0] vchar,
  output logic [2:0] hoffset,
  output logic [3:0] voffset
);
  cnt_t hcount, vcount;
  logic h_last, v_last;
  always_comb begin
    h_last = hcount == cnt_t'(h_total - 1);
    v_last = vcount == cnt_t'(v_total - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      hcount <= h_last ? '0 : hcount + cnt_t'(1);
      if (h_last) vcount <= v_last ? '0 : vcount + cnt_t'(1);
    end
  // Blanking parks the request on an out-of-range cell so the buffer stays idle.
  always_comb begin
    de = (hcount < cnt_t'(h_visible)) && (vcount < cnt_t'(v_visible));
    hs = (hcount >= cnt_t'(h_sync_start)) && (hcount < cnt_t'(h_sync_end));
    vs = (vcount >= cnt_t'(v_sync_start)) && (vcount < cnt_t'(v_sync_end));
    first = (hcount == '0) && (vcount == '0);
    hchar = de ? hcount[9:3] : '1;
    hoffset = de ? hcount[2:0] : '0;
    vchar = de ? vcount[8:4] : '1;
    voffset = de ? vcount[3:0] : '0;
  end
endmodule

// File: rtl/vga_char_scan.sv
// vga_char_scan: character-cell VGA scanner; stage 0 requests a glyph pixel, stage 1 waits for it, pins register the result.
module vga_char_scan
  import vga_pkg::*;
#(
  parameter rgb_t p_fg = 12'hFFF,
  parameter rgb_t p_bg = 12'h000,
  parameter rgb_t p_border = 12'h008
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [6:0] read_hchar,
  output logic [4:0] read_vchar,
  output logic [2:0] read_hoffset,
  output logic [3:0] read_voffset,
  input  logic       read_lit,
  input  logic       out_of_bounds,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start
);
  logic de0, hs0, vs0, first0;
  logic de1, hs1, vs1, first1;
  rgb_t colour;
  vga_timing u_timing (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .de     (de0),
    .hs     (hs0),
    .vs     (vs0),
    .first  (first0),
    .hchar  (read_hchar),
    .vchar  (read_vchar),
    .hoffset(read_hoffset),
    .voffset(read_voffset)
  );
  // Stage 1 samples every clk so the pins settle even while pix_en is low.
  always_ff @(posedge clk)
    if (rst) {de1, hs1, vs1, first1} <= '0;
    else {de1, hs1, vs1, first1} <= {de0, hs0, vs0, first0};
  always_comb colour = !de1 ? rgb_t'(0) : out_of_bounds ? p_border : read_lit ? p_fg : p_bg;
  always_ff @(posedge clk)
    if (rst) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      {vga_r, vga_g, vga_b} <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hs <= ~hs1;
      vga_vs <= ~vs1;
      {vga_r, vga_g, vga_b} <= colour;
      frame_start <= first1;
    end
endmodule

// File: tb/tb_vga_char_scan.sv
// tb_vga_char_scan: random and directed stimulus against a coordinate-level model of the scanner.
module tb_vga_char_scan;
  logic clk = 1'b0, rst = 1'b1, pix_en = 1'b1, read_lit = 1'b0, out_of_bounds = 1'b0;
  logic [6:0] read_hchar;
  logic [4:0] read_vchar;
  logic [2:0] read_hoffset;
  logic [3:0] read_voffset;
  logic vga_hs, vga_vs, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;
  logic [9:0] force_val;
  int tests = 0, fails = 0;
  int mode = 0, pmode = 0;
  int mh = 0, mv = 0, ph = 0, pv = 0;
  bit prev_ok = 0, armed = 0;
  bit exp_hs = 1, exp_vs = 1, exp_fs = 0;
  logic [11:0] exp_rgb = 0;
  int jump_cnt = 0, jump_seen = 0, jump_v = 0;
  int hs_lo, vs_lo, fs_hi, fff;

  vga_char_scan u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .read_hchar(read_hchar), .read_vchar(read_vchar),
    .read_hoffset(read_hoffset), .read_voffset(read_voffset),
    .read_lit(read_lit), .out_of_bounds(out_of_bounds),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic bit vis(input int h, input int v);
    return h < 640 && v < 480;
  endfunction
  function automatic bit hband(input int h);
    return h >= 656 && h <= 751;
  endfunction
  function automatic bit vband(input int v);
    return v >= 490 && v <= 491;
  endfunction

  // Model: pins show the coordinate present two clocks earlier, coloured by the buffer reply of the last clock.
  always @(posedge clk) begin
    if (rst) begin
      armed = 1; prev_ok = 0; mh = 0; mv = 0;
      exp_hs = 1; exp_vs = 1; exp_rgb = 0; exp_fs = 0;
    end else begin
      exp_hs = !(prev_ok && hband(ph));
      exp_vs = !(prev_ok && vband(pv));
      exp_rgb = !(prev_ok && vis(ph, pv)) ? 12'h000 : out_of_bounds ? 12'h008 : read_lit ? 12'hFFF : 12'h000;
      exp_fs = prev_ok && ph == 0 && pv == 0;
      if (jump_cnt != jump_seen) begin
        jump_seen = jump_cnt;
        mv = jump_v;
      end
      ph = mh; pv = mv; prev_ok = 1;
      if (pix_en) begin
        mh = (mh + 1) % 800;
        if (mh == 0) mv = (mv + 1) % 525;
      end
    end
  end

  always @(posedge clk) begin
    int eh, ev, eho, evo;
    #3;
    if (armed) begin
      eh = vis(mh, mv) ? mh / 8 : 127;
      eho = vis(mh, mv) ? mh % 8 : 0;
      ev = vis(mh, mv) ? mv / 16 : 31;
      evo = vis(mh, mv) ? mv % 16 : 0;
      tests += 2;
      if ({vga_hs, vga_vs, frame_start, vga_r, vga_g, vga_b} !== {exp_hs, exp_vs, exp_fs, exp_rgb}) begin
        fails++;
        $display("FAIL pins t=%0t h=%0d v=%0d: hs/vs/fs=%b%b%b rgb=%h, expected %b%b%b rgb=%h",
                 $time, mh, mv, vga_hs, vga_vs, frame_start, {vga_r, vga_g, vga_b}, exp_hs, exp_vs, exp_fs, exp_rgb);
      end
      if (int'(read_hchar) != eh || int'(read_hoffset) != eho || int'(read_vchar) != ev || int'(read_voffset) != evo) begin
        fails++;
        $display("FAIL request t=%0t h=%0d v=%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 $time, mh, mv, read_hchar, read_hoffset, read_vchar, read_voffset, eh, eho, ev, evo);
      end
    end
  end

  // Character buffer: replies one clk after the request.
  always @(posedge clk) begin
    read_lit <= mode == 0 ? read_hchar == 7'd3 : mode == 1 ? 1'($urandom % 2) : 1'b1;
    out_of_bounds <= mode == 1 ? ($urandom % 4 == 0) : mode == 2;
  end

  always @(negedge clk) pix_en = pmode == 0 ? 1'b1 : pmode == 1 ? !pix_en : 1'($urandom % 4 != 0);

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at h=%0d v=%0d", name, mh, mv);
  endtask

  task automatic wait_at(input int h, input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mh == h && mv == v) && n < 30000);
    if (n >= 30000) timeout("wait_at");
  endtask

  task automatic jump(input int v);
    int n = 0;
    while (mh != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) timeout("jump");
    force_val = 10'(v);
    force u_dut.u_timing.vcount = force_val;
    #1 release u_dut.u_timing.vcount;
    jump_v = v;
    jump_cnt++;
  endtask

  task automatic count_win(input int n);
    hs_lo = 0; vs_lo = 0; fs_hi = 0; fff = 0;
    repeat (n) begin
      @(negedge clk);
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (frame_start) fs_hi++;
      if ({vga_r, vga_g, vga_b} == 12'hFFF) fff++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hs", int'(vga_hs), 1);
    chk("reset_vs", int'(vga_vs), 1);
    chk("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("reset_fs", int'(frame_start), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("fs_after_1", int'(frame_start), 0);
    @(negedge clk);
    chk("fs_after_2", int'(frame_start), 1);
    count_win(800);
    chk("hs_low_per_line", hs_lo, 96);
    chk("lit_col3_pixels", fff, 8);
    jump(36);
    wait_at(322, 37);
    chk("req_hchar_322", int'(read_hchar), 40);
    chk("req_hoff_322", int'(read_hoffset), 2);
    chk("req_vchar_37", int'(read_vchar), 2);
    chk("req_voff_37", int'(read_voffset), 5);
    wait_at(642, 37);
    chk("blank_hchar", int'(read_hchar), 127);
    chk("blank_vchar", int'(read_vchar), 31);
    chk("blank_hoff", int'(read_hoffset), 0);
    chk("blank_voff", int'(read_voffset), 0);
    wait_at(50, 38);
    mode = 2;
    wait_at(100, 38);
    chk("oob_over_lit", int'({vga_r, vga_g, vga_b}), 12'h008);
    wait_at(700, 38);
    chk("blank_rgb", int'({vga_r, vga_g, vga_b}), 0);
    mode = 1;
    jump(488);
    count_win(8000);
    chk("vs_low_per_frame", vs_lo, 1600);
    chk("hs_low_10_lines", hs_lo, 960);
    jump(523);
    count_win(2400);
    chk("fs_per_frame", fs_hi, 1);
    pmode = 1;
    jump(524);
    count_win(3200);
    chk("fs_half_rate", fs_hi, 2);
    chk("hs_low_half_rate", hs_lo, 384);
    pmode = 0;
    mode = 0;
    jump(489);
    wait_at(100, 491);
    chk("vs_active_491", int'(vga_vs), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("vs_high_after_rst", int'(vga_vs), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_fs_1", int'(frame_start), 0);
    @(negedge clk);
    chk("restart_fs_2", int'(frame_start), 1);
    pmode = 2;
    mode = 1;
    repeat (4000) begin
      @(negedge clk);
      rst = ($urandom % 1500 == 0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
